// File: rtl/reg_dump_tx.sv
// Register-file streamer: on start, emits one frame of PC followed by x0..x31
// on a valid/ready stream, reading the register file through a debug port.
module reg_dump_tx #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [5:0]            out_index,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_REGS);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [5:0]            out_index_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  done_q;
    logic [15:0]           frame_count_q;

    logic [5:0]            out_index_d;
    logic [15:0]           frame_count_d;
    logic                  beat_xfer;

    assign out_index_d   = out_index_q + 6'd1;
    assign frame_count_d = frame_count_q + 16'd1;
    assign beat_xfer     = out_valid_q && out_ready;

    // The read address tracks the register feeding the next beat, so the
    // combinational read data is ready to be loaded on the current transfer.
    assign dbg_addr = (state_q == STREAM) ? out_index_q[ADDR_WIDTH-1:0] : '0;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            out_data_q    <= '0;
            out_index_q   <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        out_data_q  <= pc;
                        out_index_q <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        state_q     <= STREAM;
                    end
                end
                STREAM: begin
                    if (beat_xfer) begin
                        if (out_index_q == LAST_IDX) begin
                            out_valid_q   <= 1'b0;
                            out_last_q    <= 1'b0;
                            out_index_q   <= '0;
                            done_q        <= 1'b1;
                            frame_count_q <= frame_count_d;
                            state_q       <= IDLE;
                        end else begin
                            out_data_q  <= dbg_data;
                            out_index_q <= out_index_d;
                            out_last_q  <= (out_index_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data    = out_data_q;
    assign out_index   = out_index_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = (state_q == STREAM);
    assign done        = done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Self-checking bench for reg_dump_tx: a behavioural register file drives the
// debug port and each frame is compared against {pc, x0..x31} snapshots.
module tb_reg_dump_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [5:0]  out_index;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;

    logic [31:0] regs [32];
    logic [15:0] fc_model;
    int          total = 0;
    int          bad   = 0;

    reg_dump_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pc         (pc),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_index  (out_index),
        .busy       (busy),
        .done       (done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    assign dbg_data = regs[dbg_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1 plus a forced stall on
    // beat 6 while x5 is rewritten, 2: random ready.
    task automatic run_frame(input logic [31:0] pcv, input int mode, input bit prestarted,
                             input bit chain, input logic [31:0] chain_pc);
        logic [31:0] exp_q [$];
        logic [31:0] got_d [$];
        int          got_i [$];
        logic        got_l [$];
        logic [31:0] saved_x5;
        int          cyc;
        int          stalls;
        bit          finished;
        bit          poked;

        exp_q.push_back(pcv);
        for (int i = 0; i < 32; i++) exp_q.push_back(regs[i]);
        saved_x5 = regs[5];

        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
            pc    = pcv;
        end
        @(negedge clk);
        start = 1'b0;
        pc    = $urandom;
        cyc   = 1;
        check("start_latency_valid", {31'd0, out_valid}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_done_clear", {31'd0, done}, 32'd0);

        finished = 1'b0;
        poked    = 1'b0;
        stalls   = 0;
        while (!finished && cyc < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 1 && out_valid && out_index == 6'd6 && !poked) begin
                out_ready = 1'b0;
                regs[5]   = 32'hDEAD_BEEF;
                poked     = 1'b1;
            end
            if (out_valid && !out_ready) stalls++;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_i.push_back(int'(out_index));
                got_l.push_back(out_last);
                if (out_index == 6'd32) begin
                    finished = 1'b1;
                    if (chain) begin
                        start = 1'b1;
                        pc    = 32'hBAD0_BAD0;
                    end
                end
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("frame_finished", {31'd0, finished}, 32'd1);

        @(negedge clk);
        cyc++;
        fc_model = fc_model + 16'd1;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy_low", {31'd0, busy}, 32'd0);
        check("done_valid_low", {31'd0, out_valid}, 32'd0);
        check("done_last_low", {31'd0, out_last}, 32'd0);
        check("done_index_zero", {26'd0, out_index}, 32'd0);
        check("frame_count", {16'd0, frame_count}, {16'd0, fc_model});
        check("frame_cycles", cyc, 34 + stalls);

        if (chain) begin
            pc = chain_pc;
        end else begin
            out_ready = 1'b0;
            @(negedge clk);
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("idle_valid_low", {31'd0, out_valid}, 32'd0);
        end

        check("beat_count", got_d.size(), 33);
        for (int k = 0; k < got_d.size() && k < 33; k++) begin
            check($sformatf("beat%0d_data", k), got_d[k], exp_q[k]);
            check($sformatf("beat%0d_index", k), got_i[k], k);
            check($sformatf("beat%0d_last", k), {31'd0, got_l[k]}, {31'd0, k == 32});
        end
        if (poked) regs[5] = saved_x5;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_index"}, {26'd0, out_index}, 32'd0);
        check({tag, "_dbg_addr"}, {27'd0, dbg_addr}, 32'd0);
        check({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [15:0] fc_base;
        int          phase;

        rst       = 1'b0;
        start     = 1'b0;
        pc        = '0;
        out_ready = 1'b0;
        fc_model  = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);

        #3;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Plain frame, then the same frame under stalls with x5 rewritten.
        run_frame(32'h0000_0040, 0, 1'b0, 1'b0, 32'd0);
        run_frame(32'h0000_0040, 1, 1'b0, 1'b0, 32'd0);

        // Random register contents, PC and back-pressure.
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        run_frame($urandom, 2, 1'b0, 1'b0, 32'd0);

        // Start during the final beat is ignored; start on the next (done)
        // cycle is accepted and captures the PC presented then.
        run_frame(32'h1111_2222, 0, 1'b0, 1'b1, 32'h3333_4444);
        run_frame(32'h3333_4444, 0, 1'b1, 1'b0, 32'd0);

        // Start held high: back-to-back frames every 34 cycles.
        fc_base = fc_model;
        @(negedge clk);
        out_ready = 1'b1;
        start     = 1'b1;
        pc        = 32'h0000_0100;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            phase = k % 34;
            check($sformatf("b2b_valid_c%0d", k), {31'd0, out_valid}, {31'd0, phase != 0});
            check($sformatf("b2b_done_c%0d", k), {31'd0, done}, {31'd0, phase == 0});
            check($sformatf("b2b_count_c%0d", k), {16'd0, frame_count}, 32'(fc_base) + 32'(k / 34));
            if (phase != 0)
                check($sformatf("b2b_index_c%0d", k), {26'd0, out_index}, 32'(phase - 1));
        end
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        fc_model = fc_base + 16'd3;
        check("b2b_third_done", {31'd0, done}, 32'd1);
        check("b2b_final_count", {16'd0, frame_count}, {16'd0, fc_model});
        @(negedge clk);

        // Reset in the middle of a frame.
        out_ready = 1'b1;
        start     = 1'b1;
        pc        = 32'h0000_0200;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (out_index != 6'd10 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("reached_beat10", {26'd0, out_index}, 32'd10);
        #2 rst = 1'b0;
        #1 check_all_zero("midframe_reset");
        fc_model = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_idle", {31'd0, out_valid}, 32'd0);
            check("post_reset_no_done", {31'd0, done}, 32'd0);
            check("post_reset_count", {16'd0, frame_count}, 32'd0);
        end
        run_frame(32'h0000_0080, 0, 1'b0, 1'b0, 32'd0);

        // Frame counter wrap 0xFFFF -> 0x0000.
        @(negedge clk);
        force dut.frame_count_q = 16'hFFFF;
        #1 release dut.frame_count_q;
        fc_model = 16'hFFFF;
        check("preload_count", {16'd0, frame_count}, 32'h0000_FFFF);
        run_frame(32'h0000_0C00, 2, 1'b0, 1'b0, 32'd0);
        check("wrapped_count", {16'd0, frame_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
